// File: rtl/shift_sequencer.sv
// Multi-step shift/rotate sequencer: runs the combinational ALU one bit per clock,
// feeding each step's value and flags back until the count runs out or the ALU stops.

package shift_sequencer_pkg;
  localparam int unsigned MC_ALUOp_t_BITS = 5;

  typedef enum logic [MC_ALUOp_t_BITS-1:0] {
    ALUOp_SELA = 5'd0,
    ALUOp_SHL  = 5'd1,
    ALUOp_SHR  = 5'd2,
    ALUOp_SAR  = 5'd3,
    ALUOp_ROL  = 5'd4,
    ALUOp_ROR  = 5'd5,
    ALUOp_RCL  = 5'd6,
    ALUOp_RCR  = 5'd7
  } alu_op_t;
endpackage

module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [MC_ALUOp_t_BITS-1:0] op,
  input  logic                       is_8_bit,
  input  logic                       multibit,
  input  logic [15:0]                value_in,
  input  logic [4:0]                 count_in,
  input  logic [15:0]                flags_in,
  output logic [15:0]                alu_a,
  output logic [MC_ALUOp_t_BITS-1:0] alu_op,
  output logic                       alu_is_8_bit,
  output logic                       alu_multibit_shift,
  output logic [4:0]                 alu_shift_count,
  output logic [15:0]                alu_flags,
  input  logic [31:0]                alu_out,
  input  logic [15:0]                alu_flags_out,
  input  logic                       alu_busy,
  output logic [15:0]                result,
  output logic [15:0]                flags_out,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned COUNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state, next_state;
  logic                 start_accept;
  logic                 start_zero;
  logic                 run_finish;
  logic [COUNT_W-1:0]   eff_count;
  logic [COUNT_W-1:0]   count_dec;

  // Only the low half of the ALU result is meaningful here.
  logic unused_alu_hi;
  assign unused_alu_hi = ^alu_out[31:DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state plus the load strobes for the datapath registers.
  always_comb begin
    next_state   = state;
    start_accept = 1'b0;
    start_zero   = 1'b0;
    run_finish   = 1'b0;
    eff_count    = multibit ? count_in : COUNT_W'(1);
    count_dec    = alu_shift_count - COUNT_W'(1);
    case (state)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          if (eff_count == '0) begin
            start_zero = 1'b1;
            next_state = FINISH;
          end else begin
            next_state = RUN;
          end
        end
      end
      RUN: begin
        // Either condition ends the run, so a stuck alu_busy cannot hang us.
        if (!alu_busy || count_dec == '0) begin
          run_finish = 1'b1;
          next_state = FINISH;
        end
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a              <= '0;
      alu_op             <= MC_ALUOp_t_BITS'(ALUOp_SELA);
      alu_is_8_bit       <= 1'b0;
      alu_multibit_shift <= 1'b0;
      alu_shift_count    <= '0;
      alu_flags          <= '0;
      result             <= '0;
      flags_out          <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      busy <= (next_state == RUN);
      done <= (next_state == FINISH);
      if (start_accept) begin
        alu_op             <= op;
        alu_is_8_bit       <= is_8_bit;
        alu_multibit_shift <= multibit;
        alu_a              <= value_in;
        alu_flags          <= flags_in;
        alu_shift_count    <= eff_count;
      end
      // A zero count completes with the operand and flags untouched.
      if (start_zero) begin
        result    <= value_in;
        flags_out <= flags_in;
      end
      if (state == RUN) begin
        alu_a           <= alu_out[DATA_W-1:0];
        alu_flags       <= alu_flags_out;
        alu_shift_count <= count_dec;
      end
      if (run_finish) begin
        result    <= alu_out[DATA_W-1:0];
        flags_out <= alu_flags_out;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a one-bit-per-step behavioural ALU.

module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic                       clk;
  logic                       reset_n;
  logic                       start;
  logic [MC_ALUOp_t_BITS-1:0] op;
  logic                       is_8_bit;
  logic                       multibit;
  logic [15:0]                value_in;
  logic [4:0]                 count_in;
  logic [15:0]                flags_in;
  logic [15:0]                alu_a;
  logic [MC_ALUOp_t_BITS-1:0] alu_op;
  logic                       alu_is_8_bit;
  logic                       alu_multibit_shift;
  logic [4:0]                 alu_shift_count;
  logic [15:0]                alu_flags;
  logic [31:0]                alu_out;
  logic [15:0]                alu_flags_out;
  logic                       alu_busy;
  logic [15:0]                result;
  logic [15:0]                flags_out;
  logic                       busy;
  logic                       done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int busy_mode = 0;  // 0: busy while count>1, 1: stuck high, 2: always low

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [15:0] flg;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];

  shift_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .is_8_bit(is_8_bit), .multibit(multibit), .value_in(value_in),
    .count_in(count_in), .flags_in(flags_in), .alu_a(alu_a),
    .alu_op(alu_op), .alu_is_8_bit(alu_is_8_bit),
    .alu_multibit_shift(alu_multibit_shift), .alu_shift_count(alu_shift_count),
    .alu_flags(alu_flags), .alu_out(alu_out), .alu_flags_out(alu_flags_out),
    .alu_busy(alu_busy), .result(result), .flags_out(flags_out),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One shift step; upper byte passes through on 8-bit ops, only CF is touched.
  function automatic logic [31:0] alu_step(input logic [4:0] opv, input logic b8,
                                           input logic [15:0] a, input logic [15:0] f);
    logic [15:0] r;
    logic [7:0]  lo;
    logic        cf;
    logic        cin;
    r   = a;
    lo  = a[7:0];
    cin = f[0];
    cf  = cin;
    if (b8) begin
      case (alu_op_t'(opv))
        ALUOp_SHL: begin cf = lo[7]; lo = {lo[6:0], 1'b0}; end
        ALUOp_SHR: begin cf = lo[0]; lo = {1'b0, lo[7:1]}; end
        ALUOp_SAR: begin cf = lo[0]; lo = {lo[7], lo[7:1]}; end
        ALUOp_ROL: begin lo = {lo[6:0], lo[7]}; cf = lo[0]; end
        ALUOp_ROR: begin lo = {lo[0], lo[7:1]}; cf = lo[7]; end
        ALUOp_RCL: {cf, lo} = {lo, cin};
        ALUOp_RCR: {lo, cf} = {cin, lo};
        default: ;
      endcase
      r = {a[15:8], lo};
    end else begin
      case (alu_op_t'(opv))
        ALUOp_SHL: begin cf = r[15]; r = {r[14:0], 1'b0}; end
        ALUOp_SHR: begin cf = r[0]; r = {1'b0, r[15:1]}; end
        ALUOp_SAR: begin cf = r[0]; r = {r[15], r[15:1]}; end
        ALUOp_ROL: begin r = {r[14:0], r[15]}; cf = r[0]; end
        ALUOp_ROR: begin r = {r[0], r[15:1]}; cf = r[15]; end
        ALUOp_RCL: {cf, r} = {r, cin};
        ALUOp_RCR: {r, cf} = {cin, r};
        default: ;
      endcase
    end
    return {f[15:1], cf, r};
  endfunction

  always_comb begin
    logic [31:0] s;
    s             = alu_step(alu_op, alu_is_8_bit, alu_a, alu_flags);
    alu_out       = {16'h0000, s[15:0]};
    alu_flags_out = s[31:16];
    case (busy_mode)
      1:       alu_busy = 1'b1;
      2:       alu_busy = 1'b0;
      default: alu_busy = alu_multibit_shift && (alu_shift_count > 5'd1);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.res));
        chk({e.name, "_flags"}, 32'(flags_out), 32'(e.flg));
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  task automatic issue(input string name, input alu_op_t o, input logic b8, input logic mb,
                       input logic [15:0] v, input logic [4:0] c, input logic [15:0] f,
                       input bit push, input int steps,
                       input logic [15:0] er, input logic [15:0] ef);
    exp_t e;
    @(negedge clk);
    op = MC_ALUOp_t_BITS'(o); is_8_bit = b8; multibit = mb;
    value_in = v; count_in = c; flags_in = f; start = 1'b1;
    if (push) begin
      e.name = name; e.res = er; e.flg = ef; e.done_cyc = cyc + steps + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op = '0; is_8_bit = 1'b0; multibit = 1'b0;
    value_in = '0; count_in = '0; flags_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags_out), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_flags", 32'(alu_flags), 32'd0);
    chk("rst_count", 32'(alu_shift_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'(ALUOp_SELA));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    issue("t1_shl", ALUOp_SHL, 1'b0, 1'b1, 16'h0001, 5'd4, 16'h0000, 1, 4, 16'h0010, 16'h0000);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_count", 32'(alu_shift_count), 32'd4);
    drain("t1");

    issue("t2_rcl8", ALUOp_RCL, 1'b1, 1'b1, 16'h0080, 5'd2, 16'h0001, 1, 2, 16'h0003, 16'h0000);
    drain("t2");

    issue("t3_sar0", ALUOp_SAR, 1'b0, 1'b1, 16'h8000, 5'd0, 16'h0801, 1, 0, 16'h8000, 16'h0801);
    chk("t3_busy", 32'(busy), 32'd0);
    drain("t3");

    issue("t4_ror1", ALUOp_ROR, 1'b0, 1'b0, 16'h0001, 5'd7, 16'h0000, 1, 1, 16'h8000, 16'h0001);
    drain("t4");

    issue("t5_shr", ALUOp_SHR, 1'b0, 1'b1, 16'hF000, 5'd5, 16'h0000, 1, 5, 16'h0780, 16'h0000);
    issue("t5_ignored", ALUOp_SHL, 1'b0, 1'b1, 16'h00FF, 5'd2, 16'h0001, 0, 0, 16'h0, 16'h0);
    drain("t5");

    busy_mode = 2;
    issue("t7_early", ALUOp_SHL, 1'b0, 1'b1, 16'h0001, 5'd4, 16'h0000, 1, 1, 16'h0002, 16'h0000);
    drain("t7");
    busy_mode = 1;
    issue("t8_stuck", ALUOp_SAR, 1'b0, 1'b1, 16'h8000, 5'd3, 16'h0000, 1, 3, 16'hF000, 16'h0000);
    drain("t8");
    busy_mode = 0;

    issue("t9_rcr8", ALUOp_RCR, 1'b1, 1'b1, 16'hAB01, 5'd1, 16'h0000, 1, 1, 16'hAB00, 16'h0001);
    drain("t9");

    issue("t6_abort", ALUOp_ROL, 1'b0, 1'b1, 16'h1234, 5'd8, 16'h0001, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_result", 32'(result), 32'd0);
    chk("t6_flags", 32'(flags_out), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    issue("t6_after", ALUOp_ROL, 1'b0, 1'b1, 16'h8001, 5'd3, 16'h0000, 1, 3, 16'h000C, 16'h0000);
    drain("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Initiator for the ALU's shift/rotate datapath: drives operand, op, count and the `multibit_shift` flag.
- Feeds each ALU step's result and flags back into the next step until the ALU drops `busy`.
- Executes one bit per clock for SHL/SHR/SAR/ROL/ROR/RCL/RCR, including the 8-bit and count-0 forms.
- Sits between the microcode sequencer (`start`/`done`) and the combinational ALU.

Parameters:
- None. Op encoding width is `MC_ALUOp_t_BITS` from the shared microcode header.

Ports:
- clk  input  1  core clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  MC_ALUOp_t_BITS  ALUOp_SHL/SHR/SAR/ROL/ROR/RCL/RCR
- is_8_bit  input  1  byte operation
- multibit  input  1  1 = CL/imm count form; 0 = single-bit form
- value_in  input  16  operand
- count_in  input  5  shift count (already masked to 5 bits)
- flags_in  input  16  flags at start
- alu_a  output  16  current working value to ALU a
- alu_op  output  MC_ALUOp_t_BITS  latched op
- alu_is_8_bit  output  1  latched is_8_bit
- alu_multibit_shift  output  1  latched multibit
- alu_shift_count  output  5  remaining count
- alu_flags  output  16  working flags to ALU flags_in
- alu_out  input  32  ALU result; bits [15:0] used
- alu_flags_out  input  16  ALU flags result
- alu_busy  input  1  ALU requires further steps
- result  output  16  final value
- flags_out  output  16  final flags
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_n low):
  - State IDLE.
  - result, flags_out, alu_a, alu_flags, alu_shift_count = 0.
  - busy = 0, done = 0.
  - alu_op = ALUOp_SELA, other latched controls = 0.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On start, latch op, is_8_bit, multibit.
  - alu_a ← value_in; alu_flags ← flags_in.
  - Effective count = count_in if multibit, else 1.
  - Effective count 0 → FINISH, with result ← value_in and flags_out ← flags_in (flags untouched).
  - Otherwise alu_shift_count ← effective count and go to RUN.
  - busy = 1 from the cycle after start.
- RUN, every cycle:
  - Register alu_a ← alu_out[15:0], alu_flags ← alu_flags_out, alu_shift_count ← alu_shift_count − 1.
  - If alu_busy = 0, or the decremented count is 0: result ← alu_out[15:0], flags_out ← alu_flags_out, go to FINISH.
  - Either condition terminates, so a stuck busy cannot hang the block.
- FINISH:
  - done = 1 for exactly one cycle, busy = 0, return to IDLE.
  - result/flags_out hold until the next completion.
- Latency: count N ≥ 1 → N RUN cycles, done in cycle N+1 after start. Count 0 → done in cycle 1.
- start while busy or in FINISH is ignored; no queuing.
- No width change on 8-bit ops: result[15:8] is whatever the ALU returns. The sequencer never masks it.
- Count decrement never wraps: RUN is never entered with count 0.
- RCL/RCR: CF carries between steps only through the alu_flags feedback.
- Reset mid-RUN aborts immediately. No done pulse; result/flags_out cleared.

Test Plan:
1. SHL, 16-bit, value 0x0001, count 4, multibit=1, flags 0x0000 → 4 RUN cycles, done at cycle 5, result 0x0010, CF=0.
2. RCL, 8-bit, value 0x80, CF=1, count 2 → result[7:0] 0x03, CF=0, done at cycle 3.
3. SAR, 16-bit, value 0x8000, count 0, flags 0x0801 → done at cycle 1, result 0x8000, flags_out 0x0801.
4. Single-bit form: ROR, 16-bit, value 0x0001, count_in 7, multibit=0 → exactly 1 step, result 0x8000, CF=1.
5. Second start pulsed during RUN of a count-5 SHR → ignored: one done pulse, and result matches the first request only.
6. reset_n low in the 2nd RUN cycle of a count-8 op → busy=0, result=0, no done. After release, a new start completes normally.
